load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Executes data-memory accesses flagged by the decode/control stage (mem_read/mem_write).
//  Issues req/gnt/rvalid transactions to data memory and generates byte enables and write-data lane steering.
//  Sign- or zero-extends load data and returns it to the register-file writeback path.
//  Single outstanding access; stalls the pipeline through req_ready while busy.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles spent in REQ+WAIT before bus_err; 0 disables the timeout
// PORTS
//  clk          in   1   clock, all state updates on rising edge
//  rst_n        in   1   asynchronous active-low reset
//  req_valid    in   1   access request from control stage
//  req_ready    out  1   1 only in IDLE; request accepted when req_valid&req_ready
//  mem_read     in   1   load request
//  mem_write    in   1   store request
//  funct3       in   3   000 B, 001 H, 010 W, 100 BU, 101 HU
//  addr         in   32  byte address (ALU result)
//  wdata        in   32  store data (rs2), data in low bits
//  rd           in   5   load destination register
//  dmem_req     out  1   memory request; held until dmem_gnt
//  dmem_we      out  1   1 = write
//  dmem_addr    out  32  word address: {addr[31:2],2'b00}
//  dmem_be      out  4   byte lane enables
//  dmem_wdata   out  32  lane-steered store data
//  dmem_gnt     in   1   request accepted by memory
//  dmem_rvalid  in   1   read data valid
//  dmem_rdata   in   32  read data
//  wb_valid     out  1   1-cycle pulse: load result ready
//  wb_rd        out  5   destination register for the load result
//  wb_data      out  32  extended load data
//  store_done   out  1   1-cycle pulse: store granted
//  lsu_err      out  1   1-cycle pulse: illegal/misaligned request or timeout
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1; every other output 0, including dmem_*, wb_*, store_done and lsu_err.
//  Reset mid-access: dmem_req drops immediately and the access is abandoned.
//  FSM: IDLE -> REQ on an accepted, legal request.
//   REQ: dmem_req=1 with dmem_we/addr/be/wdata stable.
//    dmem_gnt & load -> WAIT. dmem_gnt & store -> IDLE and store_done=1 in the next cycle.
//   WAIT: dmem_rvalid -> RESP; rdata is captured and extended.
//   RESP: wb_valid=1 for exactly one cycle -> IDLE.
//  Latency:
//   Request accepted at cycle 0 -> dmem_req at cycle 1.
//   Load: rvalid at cycle N -> wb_valid at N+1. Minimum load latency is 3 cycles (gnt at 1, rvalid at 2).
//  Illegal request -> lsu_err=1 next cycle, no memory access, stay IDLE. Illegal means any of:
//   - mem_read & mem_write both set
//   - funct3 not in {000,001,010,100,101}
//   - funct3 = 1xx with mem_write
//  req_valid with neither mem_read nor mem_write: ignored, no response.
//  Byte enables:
//   B -> 4'b0001 << addr[1:0]
//   H -> 4'b0011 << {addr[1],1'b0}
//   W -> 4'b1111
//  Store data:
//   B -> wdata[7:0] replicated on all four lanes
//   H -> wdata[15:0] replicated on both halves
//   W -> wdata as-is
//  Load data: the selected lane is shifted to bit 0; B/H sign-extend, BU/HU zero-extend.
//  Timeout: counter cleared on entry to REQ and incremented in REQ/WAIT.
//   Reaching TIMEOUT_CYCLES -> lsu_err=1, dmem_req=0, IDLE, no wb_valid.
//  dmem_rvalid outside WAIT is ignored. dmem_gnt outside REQ is ignored.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined:
//   H with addr[0]=1, or W with addr[1:0]!=0 -> lsu_err pulse, no access, stay IDLE.
//  LSU_MISALIGN_TRAP_EN undefined:
//   - no misalignment check; address aligned down (H clears addr[0], W clears addr[1:0])
//   - access performed normally, lsu_err never set for alignment
// TESTING
//  LW addr=0x104, gnt at 1, rvalid at 2 with rdata=0xDEADBEEF -> wb_valid at 3, wb_data=0xDEADBEEF, wb_rd echoed.
//  LB addr=0x103, rdata=0x80FF_0000 -> be=1000, wb_data=0xFFFFFF80. Same with LBU -> 0x00000080.
//  SH addr=0x202, wdata=0x1234ABCD, gnt delayed 3 cycles -> dmem_req held with be=1100, wdata=0xABCDABCD; store_done 1 cycle after gnt.
//  LH addr=0x301 -> with macro: lsu_err pulse, no dmem_req. Without macro: dmem_addr=0x300, be=0011.
//  TIMEOUT_CYCLES=4, gnt never asserted -> lsu_err 4 cycles after REQ entry, then req_ready=1.
//  rst_n low while in WAIT -> dmem_req/wb_valid 0 immediately; a later rvalid produces no wb_valid.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding req/gnt/rvalid data-memory access with lane steering and load extension.
// Optional build macro LSU_MISALIGN_TRAP_EN turns misaligned H/W accesses into lsu_err instead of aligning them down.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [4:0]  rd,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        store_done,
    output logic        lsu_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam int unsigned CW = (TIMEOUT_CYCLES < 32'd2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 32'd1);
    localparam logic TMO_EN = (TIMEOUT_CYCLES != 32'd0);

    // H uses only addr[1] and W no offset bits, which aligns misaligned accesses down.
    function automatic logic [3:0] calc_be(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return 4'b0001 << a;
            2'b01:   return 4'b0011 << {a[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] calc_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] d);
        logic [31:0] sh;
        case (f3[1:0])
            2'b00:   sh = d >> {a, 3'b000};
            2'b01:   sh = d >> {a[1], 4'b0000};
            default: sh = d;
        endcase
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b100:  return {24'd0, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b101:  return {16'd0, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic [2:0]    f3_r;
    logic [1:0]    off_r;
    logic [4:0]    rd_r;
    logic          req_ready_r, dmem_req_r, dmem_we_r, wb_valid_r, store_done_r, lsu_err_r;
    logic [31:0]   dmem_addr_r, dmem_wdata_r, wb_data_r;
    logic [3:0]    dmem_be_r;
    logic [4:0]    wb_rd_r;

    logic is_access_s, f3_ok_s, misalign_s, illegal_s, tmo_hit_s;

    // Request legality decode and timeout detection.
    always_comb begin
        is_access_s = mem_read | mem_write;
        case (funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_ok_s = 1'b1;
            default:                                f3_ok_s = 1'b0;
        endcase
`ifdef LSU_MISALIGN_TRAP_EN
        misalign_s = ((funct3[1:0] == 2'b01) && addr[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
        misalign_s = 1'b0;
`endif
        illegal_s = (mem_read & mem_write) | ~f3_ok_s | (funct3[2] & mem_write) | misalign_s;
        tmo_hit_s = TMO_EN && (cnt_r == TMO_LAST);
    end

    // Access FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            f3_r         <= 3'd0;
            off_r        <= 2'd0;
            rd_r         <= 5'd0;
            req_ready_r  <= 1'b1;
            dmem_req_r   <= 1'b0;
            dmem_we_r    <= 1'b0;
            dmem_addr_r  <= 32'd0;
            dmem_be_r    <= 4'd0;
            dmem_wdata_r <= 32'd0;
            wb_valid_r   <= 1'b0;
            wb_rd_r      <= 5'd0;
            wb_data_r    <= 32'd0;
            store_done_r <= 1'b0;
            lsu_err_r    <= 1'b0;
        end else begin
            wb_valid_r   <= 1'b0;
            store_done_r <= 1'b0;
            lsu_err_r    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_valid && is_access_s) begin
                        if (illegal_s) begin
                            lsu_err_r <= 1'b1;
                        end else begin
                            state_r      <= ST_REQ;
                            cnt_r        <= '0;
                            req_ready_r  <= 1'b0;
                            dmem_req_r   <= 1'b1;
                            dmem_we_r    <= mem_write;
                            dmem_addr_r  <= {addr[31:2], 2'b00};
                            dmem_be_r    <= calc_be(funct3, addr[1:0]);
                            dmem_wdata_r <= calc_wdata(funct3, wdata);
                            f3_r         <= funct3;
                            off_r        <= addr[1:0];
                            rd_r         <= rd;
                        end
                    end
                end
                ST_REQ: begin
                    // A grant arriving on the timeout cycle still completes the access.
                    if (dmem_gnt) begin
                        dmem_req_r <= 1'b0;
                        if (dmem_we_r) begin
                            state_r      <= ST_IDLE;
                            req_ready_r  <= 1'b1;
                            store_done_r <= 1'b1;
                        end else begin
                            state_r <= ST_WAIT;
                            cnt_r   <= cnt_r + CW'(1);
                        end
                    end else if (tmo_hit_s) begin
                        state_r     <= ST_IDLE;
                        req_ready_r <= 1'b1;
                        dmem_req_r  <= 1'b0;
                        lsu_err_r   <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_WAIT: begin
                    if (dmem_rvalid) begin
                        state_r    <= ST_RESP;
                        wb_valid_r <= 1'b1;
                        wb_rd_r    <= rd_r;
                        wb_data_r  <= extend_load(f3_r, off_r, dmem_rdata);
                    end else if (tmo_hit_s) begin
                        state_r     <= ST_IDLE;
                        req_ready_r <= 1'b1;
                        lsu_err_r   <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_RESP: begin
                    state_r     <= ST_IDLE;
                    req_ready_r <= 1'b1;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    req_ready_r <= 1'b1;
                    dmem_req_r  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_r;
    assign dmem_req   = dmem_req_r;
    assign dmem_we    = dmem_we_r;
    assign dmem_addr  = dmem_addr_r;
    assign dmem_be    = dmem_be_r;
    assign dmem_wdata = dmem_wdata_r;
    assign wb_valid   = wb_valid_r;
    assign wb_rd      = wb_rd_r;
    assign wb_data    = wb_data_r;
    assign store_done = store_done_r;
    assign lsu_err    = lsu_err_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table for single accesses plus hand sequences
// for delayed grant, timeout, ignored requests and reset during an access.
module tb_load_store_unit;

    logic        clk, rst_n;
    logic        req_valid, req_ready, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic [4:0]  rd;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        wb_valid, store_done, lsu_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int checks = 0;
    int errors = 0;

    load_store_unit #(.TIMEOUT_CYCLES(32'd4)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3), .addr(addr),
        .wdata(wdata), .rd(rd), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .store_done(store_done), .lsu_err(lsu_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd_en;
        logic        wr_en;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        exp_err;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_val;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(input logic r, input logic w, input logic [2:0] f,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rdat, input logic [4:0] d,
                                input logic e, input logic [31:0] ea,
                                input logic [3:0] eb, input logic [31:0] ev);
        vec_t v;
        v.rd_en = r; v.wr_en = w; v.f3 = f; v.addr = a; v.wdata = wd; v.rdata = rdat;
        v.rd = d; v.exp_err = e; v.exp_addr = ea; v.exp_be = eb; v.exp_val = ev;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic r, input logic w, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] d);
        req_valid = 1'b1; mem_read = r; mem_write = w; funct3 = f;
        addr = a; wdata = wd; rd = d;
        tick();
        req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        issue(v.rd_en, v.wr_en, v.f3, v.addr, v.wdata, v.rd);
        if (v.exp_err) begin
            chk({tag, " lsu_err"}, 32'(lsu_err), 32'd1);
            chk({tag, " no req"}, 32'(dmem_req), 32'd0);
            chk({tag, " ready"}, 32'(req_ready), 32'd1);
            tick();
            chk({tag, " err pulse"}, 32'(lsu_err), 32'd0);
        end else begin
            chk({tag, " dmem_req"}, 32'(dmem_req), 32'd1);
            chk({tag, " not ready"}, 32'(req_ready), 32'd0);
            chk({tag, " we"}, 32'(dmem_we), 32'(v.wr_en));
            chk({tag, " addr"}, dmem_addr, v.exp_addr);
            chk({tag, " be"}, 32'(dmem_be), 32'(v.exp_be));
            if (v.wr_en) chk({tag, " wdata"}, dmem_wdata, v.exp_val);
            dmem_gnt = 1'b1;
            tick();
            dmem_gnt = 1'b0;
            chk({tag, " req dropped"}, 32'(dmem_req), 32'd0);
            if (v.wr_en) begin
                chk({tag, " store_done"}, 32'(store_done), 32'd1);
                chk({tag, " ready after st"}, 32'(req_ready), 32'd1);
                tick();
                chk({tag, " store_done pulse"}, 32'(store_done), 32'd0);
            end else begin
                chk({tag, " no early wb"}, 32'(wb_valid), 32'd0);
                dmem_rvalid = 1'b1; dmem_rdata = v.rdata;
                tick();
                dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
                chk({tag, " wb_valid"}, 32'(wb_valid), 32'd1);
                chk({tag, " wb_data"}, wb_data, v.exp_val);
                chk({tag, " wb_rd"}, 32'(wb_rd), 32'(v.rd));
                tick();
                chk({tag, " wb pulse"}, 32'(wb_valid), 32'd0);
                chk({tag, " ready after ld"}, 32'(req_ready), 32'd1);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        funct3 = 3'd0; addr = 32'd0; wdata = 32'd0; rd = 5'd0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;

        vecs[0]  = mk(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 32'hDEADBEEF, 5'd5,  1'b0, 32'h104, 4'b1111, 32'hDEADBEEF);
        vecs[1]  = mk(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 5'd7,  1'b0, 32'h100, 4'b1000, 32'hFFFFFF80);
        vecs[2]  = mk(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 5'd8,  1'b0, 32'h100, 4'b1000, 32'h00000080);
        vecs[3]  = mk(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h80011234, 5'd9,  1'b0, 32'h100, 4'b1100, 32'hFFFF8001);
        vecs[4]  = mk(1'b1, 1'b0, 3'b101, 32'h100, 32'h0, 32'h0000F00D, 5'd10, 1'b0, 32'h100, 4'b0011, 32'h0000F00D);
        vecs[5]  = mk(1'b1, 1'b0, 3'b000, 32'h101, 32'h0, 32'h00007F00, 5'd11, 1'b0, 32'h100, 4'b0010, 32'h0000007F);
        vecs[6]  = mk(1'b0, 1'b1, 3'b000, 32'h202, 32'h000000A5, 32'h0, 5'd0, 1'b0, 32'h200, 4'b0100, 32'hA5A5A5A5);
        vecs[7]  = mk(1'b0, 1'b1, 3'b010, 32'h208, 32'h11223344, 32'h0, 5'd0, 1'b0, 32'h208, 4'b1111, 32'h11223344);
        vecs[8]  = mk(1'b0, 1'b1, 3'b001, 32'h200, 32'hFFFF5678, 32'h0, 5'd0, 1'b0, 32'h200, 4'b0011, 32'h56785678);
        vecs[9]  = mk(1'b1, 1'b1, 3'b010, 32'h100, 32'h0, 32'h0, 5'd1, 1'b1, 32'h0, 4'b0000, 32'h0);
        vecs[10] = mk(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 5'd1, 1'b1, 32'h0, 4'b0000, 32'h0);
        vecs[11] = mk(1'b0, 1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 5'd1, 1'b1, 32'h0, 4'b0000, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        vecs[12] = mk(1'b1, 1'b0, 3'b001, 32'h301, 32'h0, 32'h12345678, 5'd12, 1'b1, 32'h0, 4'b0000, 32'h0);
        vecs[13] = mk(1'b1, 1'b0, 3'b010, 32'h10E, 32'h0, 32'hCAFEF00D, 5'd13, 1'b1, 32'h0, 4'b0000, 32'h0);
`else
        vecs[12] = mk(1'b1, 1'b0, 3'b001, 32'h301, 32'h0, 32'h12345678, 5'd12, 1'b0, 32'h300, 4'b0011, 32'h00005678);
        vecs[13] = mk(1'b1, 1'b0, 3'b010, 32'h10E, 32'h0, 32'hCAFEF00D, 5'd13, 1'b0, 32'h10C, 4'b1111, 32'hCAFEF00D);
`endif

        // Reset values
        #12;
        chk("rst req_ready", 32'(req_ready), 32'd1);
        chk("rst dmem_req", 32'(dmem_req), 32'd0);
        chk("rst dmem_be", 32'(dmem_be), 32'd0);
        chk("rst dmem_addr", dmem_addr, 32'd0);
        chk("rst wb_valid", 32'(wb_valid), 32'd0);
        chk("rst wb_data", wb_data, 32'd0);
        chk("rst store_done", 32'(store_done), 32'd0);
        chk("rst lsu_err", 32'(lsu_err), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

        // SH with grant held off for three cycles
        issue(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 5'd0);
        for (int c = 0; c < 3; c++) begin
            chk("sh hold req", 32'(dmem_req), 32'd1);
            chk("sh hold be", 32'(dmem_be), 32'hC);
            chk("sh hold wdata", dmem_wdata, 32'hABCDABCD);
            chk("sh no done", 32'(store_done), 32'd0);
            tick();
        end
        chk("sh req at gnt", 32'(dmem_req), 32'd1);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        chk("sh store_done", 32'(store_done), 32'd1);
        chk("sh no err", 32'(lsu_err), 32'd0);
        tick();
        chk("sh done pulse", 32'(store_done), 32'd0);

        // Timeout with no grant: four cycles of request, then error
        issue(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 5'd3);
        for (int c = 0; c < 4; c++) begin
            chk("tmo req held", 32'(dmem_req), 32'd1);
            chk("tmo no early err", 32'(lsu_err), 32'd0);
            tick();
        end
        chk("tmo lsu_err", 32'(lsu_err), 32'd1);
        chk("tmo req drop", 32'(dmem_req), 32'd0);
        chk("tmo ready", 32'(req_ready), 32'd1);
        dmem_rvalid = 1'b1; dmem_rdata = 32'h11111111;
        tick();
        dmem_rvalid = 1'b0;
        chk("tmo no wb", 32'(wb_valid), 32'd0);
        chk("tmo err pulse", 32'(lsu_err), 32'd0);

        // Request with neither read nor write, and stray gnt/rvalid in IDLE
        issue(1'b0, 1'b0, 3'b010, 32'h500, 32'h0, 5'd4);
        chk("nop no req", 32'(dmem_req), 32'd0);
        chk("nop no err", 32'(lsu_err), 32'd0);
        chk("nop ready", 32'(req_ready), 32'd1);
        dmem_gnt = 1'b1; dmem_rvalid = 1'b1;
        tick();
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        chk("idle gnt ignored", 32'(store_done), 32'd0);
        chk("idle rvalid ignored", 32'(wb_valid), 32'd0);

        // Reset during REQ drops dmem_req without a clock edge
        issue(1'b1, 1'b0, 3'b010, 32'h600, 32'h0, 5'd6);
        chk("rstreq req", 32'(dmem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstreq req drop", 32'(dmem_req), 32'd0);
        chk("rstreq ready", 32'(req_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();

        // Reset during WAIT; later rvalid yields no writeback
        issue(1'b1, 1'b0, 3'b010, 32'h700, 32'h0, 5'd14);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rstwait req", 32'(dmem_req), 32'd0);
        chk("rstwait wb", 32'(wb_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        dmem_rvalid = 1'b1; dmem_rdata = 32'h22222222;
        tick();
        dmem_rvalid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("rstwait no wb", 32'(wb_valid), 32'd0);
            tick();
        end

        // Unit still operational after reset
        run_vec(0, vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
